// File: rtl/sha3_ctrl_pkg.sv
// Shared types and constants for the SHA3 message-sequencing controller.
package sha3_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } sha3_state_e;

  localparam int         RATE_BITS_DEF = 1344;
  localparam int         RB            = RATE_BITS_DEF / 8;
  localparam int         NW            = RATE_BITS_DEF / 32;
  localparam logic [7:0] DS_BYTE_DEF   = 8'h1F;
  localparam logic [7:0] PAD_END       = 8'h80;

endpackage

// File: rtl/sha3_digest_serializer.sv
// Holds one rate-sized digest and streams it out as 32-bit words, word 0 first.
module sha3_digest_serializer
  import sha3_ctrl_pkg::*;
#(
  parameter int NWORDS = NW
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  load_i,
  input  logic [NWORDS*32-1:0]  din_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [31:0]           data_o,
  output logic                  last_o
);

  localparam int             IW       = $clog2(NWORDS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NWORDS - 1);

  logic [NWORDS-1:0][31:0] word_q;
  logic [IW-1:0]           idx_q;
  logic                    valid_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      word_q  <= din_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      if (idx_q == LAST_IDX) begin
        valid_q <= 1'b0;
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = valid_q ? word_q[idx_q] : 32'h0;
  assign last_o  = valid_q && (idx_q == LAST_IDX);

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// Packs a 32-bit message stream into rate blocks with SHAKE padding, drives the
// SHA3 core one permutation per block and streams the final digest back out.
//
// state | meaning
// FILL  | accepting message words into the block buffer
// RUN   | permutation issued, waiting for core_done (pad-only block may follow)
// OUT   | streaming the captured digest words
module sha3_absorb_ctrl
  import sha3_ctrl_pkg::*;
#(
  parameter int         RATE_BITS = RB * 8,
  parameter logic [7:0] DS_BYTE   = DS_BYTE_DEF
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_data,
  input  logic                 s_last,
  input  logic [2:0]           s_bytes,
  output logic [RATE_BITS-1:0] core_block,
  output logic                 core_init,
  output logic                 core_go,
  input  logic                 core_done,
  input  logic [RATE_BITS-1:0] core_digest,
  output logic                 d_valid,
  input  logic                 d_ready,
  output logic [31:0]          d_data,
  output logic                 d_last,
  output logic                 busy
);

  localparam int              NW_P     = RATE_BITS / 32;
  localparam int              WIW      = $clog2(NW_P);
  localparam int              PW       = WIW + 3;
  localparam logic [WIW-1:0]  LAST_W   = WIW'(NW_P - 1);
  localparam logic [PW-1:0]   RB_BYTES = PW'(RATE_BITS / 8);

  sha3_state_e                  state_q;
  logic                         first_q, final_q, pad_pend_q, kick_q;
  logic                         go_q, init_q, ready_q;
  logic [WIW-1:0]               widx_q;
  logic [NW_P-1:0][3:0][7:0]    buf_q;

  logic [NW_P-1:0][3:0][7:0]    fill_blk_d, pad_blk_d;
  logic [3:0][7:0]              din, wr;
  logic [2:0]                   nb;
  logic [PW-1:0]                pos;
  logic                         ser_load;

  // Buffer image after writing the incoming word, padded when it is the last one.
  always_comb begin
    nb = s_bytes;
    if (!s_last || (s_bytes > 3'd4)) nb = 3'd4;
    din   = s_data;
    wr    = '0;
    wr[0] = (nb > 3'd0) ? din[0] : 8'h00;
    wr[1] = (nb > 3'd1) ? din[1] : 8'h00;
    wr[2] = (nb > 3'd2) ? din[2] : 8'h00;
    wr[3] = (nb > 3'd3) ? din[3] : 8'h00;
    pos   = {1'b0, widx_q, 2'b00} + {{(PW-3){1'b0}}, nb};
    fill_blk_d         = buf_q;
    fill_blk_d[widx_q] = wr;
    if (s_last && (pos < RB_BYTES)) begin
      fill_blk_d[pos[WIW+1:2]][pos[1:0]] = fill_blk_d[pos[WIW+1:2]][pos[1:0]] ^ DS_BYTE;
      fill_blk_d[NW_P-1][3]              = fill_blk_d[NW_P-1][3] | PAD_END;
    end
    pad_blk_d             = '0;
    pad_blk_d[0][0]       = DS_BYTE;
    pad_blk_d[NW_P-1][3]  = PAD_END;
  end

  assign ser_load = (state_q == ST_RUN) && !kick_q && core_done && final_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_FILL;
      first_q    <= 1'b1;
      final_q    <= 1'b0;
      pad_pend_q <= 1'b0;
      kick_q     <= 1'b0;
      go_q       <= 1'b0;
      init_q     <= 1'b0;
      ready_q    <= 1'b0;
      widx_q     <= '0;
      buf_q      <= '0;
    end else begin
      go_q   <= 1'b0;
      init_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          ready_q <= 1'b1;
          if (s_valid && ready_q) begin
            buf_q  <= fill_blk_d;
            widx_q <= widx_q + WIW'(1);
            if (s_last || (widx_q == LAST_W)) begin
              state_q    <= ST_RUN;
              ready_q    <= 1'b0;
              go_q       <= 1'b1;
              init_q     <= first_q;
              first_q    <= 1'b0;
              final_q    <= s_last && (pos < RB_BYTES);
              pad_pend_q <= s_last && (pos == RB_BYTES);
            end
          end
        end
        ST_RUN: begin
          if (kick_q) begin
            kick_q <= 1'b0;
            go_q   <= 1'b1;
          end else if (core_done) begin
            if (final_q) begin
              state_q <= ST_OUT;
            end else if (pad_pend_q) begin
              // Message ended exactly on a block boundary: absorb a pad-only block.
              buf_q      <= pad_blk_d;
              final_q    <= 1'b1;
              pad_pend_q <= 1'b0;
              kick_q     <= 1'b1;
            end else begin
              buf_q   <= '0;
              widx_q  <= '0;
              state_q <= ST_FILL;
              ready_q <= 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (d_valid && d_ready && d_last) begin
            first_q <= 1'b1;
            final_q <= 1'b0;
            buf_q   <= '0;
            widx_q  <= '0;
            state_q <= ST_FILL;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  sha3_digest_serializer #(.NWORDS(NW_P)) u_ser (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .load_i  (ser_load),
    .din_i   (core_digest),
    .valid_o (d_valid),
    .ready_i (d_ready),
    .data_o  (d_data),
    .last_o  (d_last)
  );

  assign s_ready    = ready_q;
  assign core_go    = go_q;
  assign core_init  = init_q;
  assign core_block = buf_q;
  assign busy       = !((state_q == ST_FILL) && (widx_q == '0));

endmodule
